// File: rtl/serial_packet_router.sv
// Serial packet receiver/demultiplexer: start bit, port field, length field, payload and an
// optional even-parity bit, MSB first; payload bits are steered live to the addressed port.
module serial_packet_router #(
    parameter int PORT_BITS = 2,
    parameter int LEN_BITS  = 4,
    parameter int PARITY_EN = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      serin,
    output logic                      dout,
    output logic [(2**PORT_BITS)-1:0] dout_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      parity_err
);

    localparam int NUM_PORTS = 2**PORT_BITS;
    localparam int FMAX      = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
    localparam int CW        = $clog2(FMAX + 1);

    typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, PARITY} state_t;

    state_t               state_q, state_d;
    logic [PORT_BITS-1:0] port_q, port_d, port_shift;
    logic [LEN_BITS-1:0]  len_q, len_d, len_shift;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 busy_q, done_q, done_d, perr_q, perr_d;

    assign port_shift = (port_q << 1) | PORT_BITS'(serin);
    assign len_shift  = (len_q << 1) | LEN_BITS'(serin);

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (!serin) begin
                        state_d = PORT;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                PORT: begin
                    port_d = port_shift;
                    par_d  = par_q ^ serin;
                    if (cnt_q == CW'(PORT_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = LEN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                LEN: begin
                    len_d = len_shift;
                    par_d = par_q ^ serin;
                    if (cnt_q == CW'(LEN_BITS - 1)) begin
                        cnt_d = '0;
                        if (len_shift != '0) begin
                            state_d = DATA;
                        end else if (PARITY_EN != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    par_d = par_q ^ serin;
                    len_d = len_q - LEN_BITS'(1);
                    // len_q counts the bits still to come, including this one
                    if (len_q == LEN_BITS'(1)) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PARITY: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    perr_d  = par_q ^ serin;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

    assign dout       = serin;
    assign busy       = busy_q;
    assign done       = done_q;
    assign parity_err = perr_q;

    // Qualifier is combinational so the payload bit is routed in the same cycle it is sampled
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
        assign dout_valid[gi] = clk_en && (state_q == DATA) && (port_q == PORT_BITS'(gi));
    end

endmodule
